// File: rtl/hand_scorer.sv
// rtl/hand_scorer.sv - per-hand registered baccarat score, count and status flags
// Optional natural detection: define HAND_SCORER_NATURAL_EN to build it, otherwise natural is tied to 0.
module hand_scorer #(
  parameter int NUM_HANDS = 2,
  parameter int MAX_CARDS = 3,
  parameter int MOD       = 10,
  localparam int CW = $clog2(MAX_CARDS + 1),
  localparam int HW = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1
) (
  input  logic                    slow_clock,
  input  logic                    resetb,
  input  logic                    clear,
  input  logic                    card_valid,
  input  logic [HW-1:0]           card_hand,
  input  logic [3:0]              card_value,
  output logic                    card_accept,
  output logic                    card_reject,
  output logic [4*NUM_HANDS-1:0]  total,
  output logic [CW*NUM_HANDS-1:0] count,
  output logic [NUM_HANDS-1:0]    full,
  output logic [NUM_HANDS-1:0]    natural
);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL_ST} state_t;

  logic                 legal;
  logic [3:0]           card_pts;
  logic [NUM_HANDS-1:0] hit;
  logic                 tgt_full;
  logic                 take_card;
  logic                 drop_card;

  assign legal    = (card_value >= 4'd1) && (card_value <= 4'd13);
  assign card_pts = (card_value <= 4'd9) ? card_value : 4'd0;

  // An out-of-range hand index matches no hand, so hit stays all-zero.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_HANDS; i++) begin
      if (card_hand == HW'(i)) hit[i] = 1'b1;
    end
  end

  assign tgt_full  = |(hit & full);
  assign take_card = card_valid && !clear && legal && (|hit) && !tgt_full;
  assign drop_card = card_valid && !clear && !take_card;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      card_accept <= 1'b0;
      card_reject <= 1'b0;
    end else begin
      card_accept <= take_card;
      card_reject <= drop_card;
    end
  end

  for (genvar g = 0; g < NUM_HANDS; g++) begin : g_hand
    state_t        st, st_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    tot, tot_nxt;
    logic [4:0]    sum;
    logic          hand_full;

    always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
        st  <= EMPTY;
        cnt <= '0;
        tot <= '0;
      end else begin
        st  <= st_nxt;
        cnt <= cnt_nxt;
        tot <= tot_nxt;
      end
    end

    // Incremental modulo: both operands are below MOD, so one subtraction suffices.
    always_comb begin
      st_nxt  = st;
      cnt_nxt = cnt;
      tot_nxt = tot;
      sum     = {1'b0, tot} + {1'b0, card_pts};
      if (clear) begin
        st_nxt  = EMPTY;
        cnt_nxt = '0;
        tot_nxt = '0;
      end else if (take_card && hit[g]) begin
        cnt_nxt = cnt + CW'(1);
        tot_nxt = (sum >= 5'(MOD)) ? 4'(sum - 5'(MOD)) : sum[3:0];
        st_nxt  = (cnt_nxt == CW'(MAX_CARDS)) ? FULL_ST : PARTIAL;
      end
    end

    always_comb begin
      hand_full = (st == FULL_ST);
    end

    assign total[4*g +: 4]  = tot;
    assign count[CW*g +: CW] = cnt;
    assign full[g]          = hand_full;

`ifdef HAND_SCORER_NATURAL_EN
    assign natural[g] = (MAX_CARDS >= 2) && (int'(cnt) == 2) && (tot >= 4'(MOD - 2));
`else
    assign natural[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_hand_scorer.sv
// tb/tb_hand_scorer.sv - directed self-checking bench for hand_scorer
module tb_hand_scorer;

`ifdef HAND_SCORER_NATURAL_EN
  localparam logic NAT = 1'b1;
`else
  localparam logic NAT = 1'b0;
`endif

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic       clear = 1'b0;
  logic       card_valid = 1'b0;
  logic       card_hand = 1'b0;
  logic [3:0] card_value = 4'd0;
  logic       card_accept, card_reject;
  logic [7:0] total;
  logic [3:0] count;
  logic [1:0] full, natural;

  logic       c3_valid = 1'b0;
  logic [1:0] c3_hand = 2'd0;
  logic [3:0] c3_value = 4'd0;
  logic       c3_accept, c3_reject;
  logic [11:0] c3_total;
  logic [5:0]  c3_count;
  logic [2:0]  c3_full, c3_natural;

  int n_cmp = 0;
  int n_fail = 0;
  int acc_seen = 0;

  always #5 slow_clock = ~slow_clock;

  hand_scorer dut (
    .slow_clock(slow_clock), .resetb(resetb), .clear(clear),
    .card_valid(card_valid), .card_hand(card_hand), .card_value(card_value),
    .card_accept(card_accept), .card_reject(card_reject),
    .total(total), .count(count), .full(full), .natural(natural)
  );

  hand_scorer #(.NUM_HANDS(3)) dut3 (
    .slow_clock(slow_clock), .resetb(resetb), .clear(clear),
    .card_valid(c3_valid), .card_hand(c3_hand), .card_value(c3_value),
    .card_accept(c3_accept), .card_reject(c3_reject),
    .total(c3_total), .count(c3_count), .full(c3_full), .natural(c3_natural)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic card(input logic h, input logic [3:0] v);
    card_valid = 1'b1;
    card_hand  = h;
    card_value = v;
    @(posedge slow_clock);
    #1;
    card_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge slow_clock);
    #1;
  endtask

  initial begin
    #12;
    chk("rst_total", total, 0);
    chk("rst_count", count, 0);
    chk("rst_flags", {card_accept, card_reject, full, natural}, 0);
    resetb = 1'b1;
    idle();

    card(1'b0, 4'd7);
    chk("first7_total", total, 8'h07);
    chk("first7_count", count, 4'b0001);
    chk("first7_acc", {card_accept, card_reject}, 2'b10);

    #2 resetb = 1'b0;
    #1;
    chk("async_rst_total", total, 0);
    chk("async_rst_misc", {count, card_accept, full}, 0);
    idle();
    chk("hold_rst", {total, count, card_accept, card_reject}, 0);
    #2 resetb = 1'b1;
    idle();
    card(1'b0, 4'd7);
    chk("rel7_total", total, 8'h07);
    chk("rel7_count", count, 4'b0001);

    clear = 1'b1;
    idle();
    clear = 1'b0;
    chk("clear_total", {total, count}, 0);

    card(1'b0, 4'd4);
    chk("nat4_total", total, 8'h04);
    card(1'b0, 4'd5);
    chk("nat9_total", total, 8'h09);
    chk("nat9_count", count, 4'b0010);
    chk("nat9_natural", natural, {1'b0, NAT});
    card(1'b0, 4'd13);
    chk("third_total", total, 8'h09);
    chk("third_count", count, 4'b0011);
    chk("third_natural", natural, 2'b00);
    chk("third_full", full, 2'b01);

    card(1'b1, 4'd8);
    acc_seen += int'(card_accept);
    chk("wrap8", total, 8'h89);
    card(1'b1, 4'd7);
    acc_seen += int'(card_accept);
    chk("wrap5", total, 8'h59);
    card(1'b1, 4'd6);
    acc_seen += int'(card_accept);
    chk("wrap1", total, 8'h19);
    chk("wrap_acc3", acc_seen, 3);
    chk("wrap_full", full, 2'b11);
    card(1'b1, 4'd2);
    chk("full_rej", {card_accept, card_reject}, 2'b01);
    chk("full_total", total, 8'h19);
    chk("full_count", count, 4'b1111);
    idle();
    chk("rej_pulse_end", {card_accept, card_reject}, 2'b00);

    clear = 1'b1;
    card(1'b0, 4'd3);
    clear = 1'b0;
    chk("clr_prec_state", {total, count, full}, 0);
    chk("clr_prec_pulse", {card_accept, card_reject}, 2'b00);

    card(1'b0, 4'd0);
    chk("ill0_rej", {card_accept, card_reject}, 2'b01);
    card(1'b0, 4'd14);
    chk("ill14_rej", {card_accept, card_reject}, 2'b01);
    card(1'b1, 4'd15);
    chk("ill15_rej", {card_accept, card_reject}, 2'b01);
    chk("ill_state", {total, count, full}, 0);

    c3_valid = 1'b1; c3_hand = 2'd3; c3_value = 4'd5;
    idle();
    chk("oor_rej", {c3_accept, c3_reject}, 2'b01);
    chk("oor_state", {c3_total, c3_count}, 0);
    c3_hand = 2'd2;
    idle();
    c3_valid = 1'b0;
    chk("h2_acc", {c3_accept, c3_reject}, 2'b10);
    chk("h2_total", c3_total, 12'h500);

    card(1'b0, 4'd12);
    card(1'b0, 4'd7);
    chk("face0_total", total, 8'h07);
    chk("face0_natural", natural, 2'b00);
    card(1'b1, 4'd3);
    card(1'b1, 4'd5);
    chk("nat8_total", total, 8'h87);
    chk("nat8_natural", natural, {NAT, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
